// File: rtl/execute_stage.sv
// Execute stage: 4-op ALU with registered result and Z/N/C condition codes.
// Optional macro EXEC_STALL_EN adds a stall input that freezes both output registers.
module execute_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef EXEC_STALL_EN
  input  logic             stall,
`endif
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic [1:0]       ALUmode,
  input  logic [1:0]       carrySelect,
  output logic [WIDTH-1:0] result_r,
  output logic [2:0]       conditionCodeRegister_r
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_AND = 2'b10;
  localparam logic [1:0] MODE_OR  = 2'b11;

  localparam logic [1:0] CS_ALU   = 2'b00;
  localparam logic [1:0] CS_SET   = 2'b01;
  localparam logic [1:0] CS_CLR   = 2'b10;
  localparam logic [1:0] CS_HOLD  = 2'b11;

  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       ccr_q, ccr_d;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_has_carry;
  logic             carry_next;
  logic             load_en;

`ifdef EXEC_STALL_EN
  assign load_en = ~stall;
`else
  assign load_en = 1'b1;
`endif

  // Extra top bit captures carry-out on add and borrow on subtract
  assign sum_ext  = {1'b0, Op1} + {1'b0, Op2};
  assign diff_ext = {1'b0, Op1} - {1'b0, Op2};

  always_comb begin
    alu_res       = '0;
    alu_cout      = 1'b0;
    alu_has_carry = 1'b0;
    case (ALUmode)
      MODE_ADD: begin
        alu_res       = sum_ext[WIDTH-1:0];
        alu_cout      = sum_ext[WIDTH];
        alu_has_carry = 1'b1;
      end
      MODE_SUB: begin
        alu_res       = diff_ext[WIDTH-1:0];
        alu_cout      = diff_ext[WIDTH];
        alu_has_carry = 1'b1;
      end
      MODE_AND: alu_res = Op1 & Op2;
      MODE_OR:  alu_res = Op1 | Op2;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    carry_next = ccr_q[2];
    case (carrySelect)
      CS_ALU:  carry_next = alu_has_carry ? alu_cout : ccr_q[2];
      CS_SET:  carry_next = 1'b1;
      CS_CLR:  carry_next = 1'b0;
      CS_HOLD: carry_next = ccr_q[2];
      default: carry_next = ccr_q[2];
    endcase
  end

  always_comb begin
    result_d = result_q;
    ccr_d    = ccr_q;
    if (load_en) begin
      result_d = alu_res;
      ccr_d    = {carry_next, alu_res[WIDTH-1], (alu_res == '0)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      ccr_q    <= 3'b000;
    end else begin
      result_q <= result_d;
      ccr_q    <= ccr_d;
    end
  end

  assign result_r                = result_q;
  assign conditionCodeRegister_r = ccr_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized
// traffic compared against an arithmetic reference model.
module tb_execute_stage;

  localparam int W = 16;
  localparam int unsigned MASK = 32'h0000_FFFF;

  logic         clk;
  logic         reset;
  logic         stall_i;
  logic [W-1:0] op1, op2;
  logic [1:0]   alu_mode, carry_sel;
  logic [W-1:0] result_r;
  logic [2:0]   ccr_r;

  int checks   = 0;
  int failures = 0;

  int unsigned m_res;
  bit          m_c, m_z, m_n;

  execute_stage #(.WIDTH(W)) dut (
    .clk                    (clk),
    .reset                  (reset),
`ifdef EXEC_STALL_EN
    .stall                  (stall_i),
`endif
    .Op1                    (op1),
    .Op2                    (op2),
    .ALUmode                (alu_mode),
    .carrySelect            (carry_sel),
    .result_r               (result_r),
    .conditionCodeRegister_r(ccr_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_ccr();
    return {m_c, m_n, m_z};
  endfunction

  task automatic model_reset();
    m_res = 0; m_c = 0; m_z = 0; m_n = 0;
  endtask

  // Reference: plain integer arithmetic on the operation's definition
  task automatic model_step(input int unsigned a, input int unsigned b,
                            input int unsigned mode, input int unsigned cs,
                            input bit stl);
    int unsigned r;
    bit cout, has_c;
`ifdef EXEC_STALL_EN
    if (stl) return;
`endif
    cout = 0; has_c = 0; r = 0;
    case (mode)
      0: begin r = a + b; cout = (r > MASK); has_c = 1; end
      1: begin r = a + 32'h1_0000 - b; cout = (a < b); has_c = 1; end
      2: r = a & b;
      default: r = a | b;
    endcase
    r = r & MASK;
    if (cs == 1) m_c = 1;
    else if (cs == 2) m_c = 0;
    else if (cs == 0 && has_c) m_c = cout;
    m_res = r;
    m_z = (r == 0);
    m_n = (r >= 32'h8000);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked 1 unit after the next one
  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] mode, input logic [1:0] cs, input bit stl);
    op1 = a; op2 = b; alu_mode = mode; carry_sel = cs; stall_i = stl;
    @(posedge clk);
    #1;
    model_step(a, b, mode, cs, stl);
    check("model_result", {16'h0, result_r}, m_res);
    check("model_ccr", {29'h0, ccr_r}, {29'h0, m_ccr()});
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_async_result", {16'h0, result_r}, 32'h0);
    check("rst_async_ccr", {29'h0, ccr_r}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    check("rst_hold_result", {16'h0, result_r}, 32'h0);
    check("rst_hold_ccr", {29'h0, ccr_r}, 32'h0);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    reset = 1'b1; stall_i = 1'b0;
    op1 = '0; op2 = '0; alu_mode = '0; carry_sel = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset_result", {16'h0, result_r}, 32'h0);
    check("reset_ccr", {29'h0, ccr_r}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step(16'd15, 16'd24, 2'b00, 2'b10, 1'b0);
      check("add_clr_result", {16'h0, result_r}, 32'h27);
      check("add_clr_ccr", {29'h0, ccr_r}, 32'h0);
    end

`ifdef EXEC_STALL_EN
    for (int i = 0; i < 2; i++) begin
      step(16'd1, 16'd1, 2'b00, 2'b00, 1'b1);
      check("stall_hold", {16'h0, result_r}, 32'h27);
    end
    step(16'd1, 16'd1, 2'b00, 2'b00, 1'b0);
    check("stall_release", {16'h0, result_r}, 32'h2);
`endif

    pulse_reset();

    step(16'hFFFF, 16'h0001, 2'b00, 2'b00, 1'b0);
    check("add_cz_result", {16'h0, result_r}, 32'h0);
    check("add_cz_ccr", {29'h0, ccr_r}, 32'b101);

    step(16'd5, 16'd7, 2'b01, 2'b00, 1'b0);
    check("sub_bn_result", {16'h0, result_r}, 32'hFFFE);
    check("sub_bn_ccr", {29'h0, ccr_r}, 32'b110);

    step(16'h00F0, 16'h0F0F, 2'b10, 2'b01, 1'b0);
    check("and_set_result", {16'h0, result_r}, 32'h0);
    check("and_set_ccr", {29'h0, ccr_r}, 32'b101);

    step(16'h00F0, 16'h0F0F, 2'b11, 2'b11, 1'b0);
    check("or_hold_result", {16'h0, result_r}, 32'h0FFF);
    check("or_hold_ccr", {29'h0, ccr_r}, 32'b100);

    // Logic ops with carrySelect=00 must keep the existing carry
    step(16'h0000, 16'h0000, 2'b10, 2'b00, 1'b0);
    check("and_keep_ccr", {29'h0, ccr_r}, 32'b101);

    for (int i = 0; i < 400; i++) begin
      bit stl;
      stl = ($urandom_range(0, 3) == 0);
      step(pick_operand(), pick_operand(), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), stl);
      if ($urandom_range(0, 59) == 0) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the 16-bit RISC pipeline.
- Takes two operands from the ID/EX boundary and applies one of four ALU operations selected by ALUmode.
- Registers the result and the 3-bit condition code register (CCR) for the EX/MEM boundary.
- carrySelect controls the carry flag, so the stage also implements SETC/CLRC-style instructions.

Parameters:
- WIDTH, 16, datapath width of Op1, Op2 and result_r. CCR is always 3 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all registered outputs.
- Op1  input  WIDTH  first ALU operand.
- Op2  input  WIDTH  second ALU operand.
- ALUmode  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- carrySelect  input  2  carry control: 00 C from ALU, 01 force C=1, 10 force C=0, 11 hold C.
- result_r  output  WIDTH  registered ALU result.
- conditionCodeRegister_r  output  3  registered flags: bit0 Z (zero), bit1 N (negative), bit2 C (carry).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset:
  - result_r = 0 and conditionCodeRegister_r = 3'b000 immediately on reset assertion, independent of clk.
  - Outputs hold these values while reset is high.
  - Reset mid-operation discards the in-flight result.
- Latency:
  - Combinational ALU followed by output registers; inputs sampled on rising clk appear on outputs after that edge (1 cycle).
  - Result and flags update every cycle; no handshake or valid signal.
- Arithmetic, all WIDTH-bit with wrap-around:
  - ADD: {cout, sum} = Op1 + Op2; result = sum.
  - SUB: result = Op1 - Op2 (two's complement); cout = borrow = 1 when Op1 < Op2 unsigned.
  - AND: result = Op1 & Op2; cout undefined, not used.
  - OR: result = Op1 | Op2; cout not used.
- Z = 1 when next result == 0. N = next result[WIDTH-1]. Z and N update every cycle for all modes.
- C update per carrySelect:
  - 00: ADD/SUB take cout; AND/OR keep the previous C.
  - 01: C = 1.
  - 10: C = 0.
  - 11: keep the previous C.
- carrySelect has priority over ALU carry generation. Flags are computed from the same-cycle result, not the registered one.
- Overflow is not flagged. 0x8000 results set N.

Optional Feature:
- Macro EXEC_STALL_EN.
- When defined:
  - Adds input port stall (1 bit).
  - While stall = 1 on a rising edge, result_r and conditionCodeRegister_r hold their values.
  - Reset still overrides stall.
- When not defined: no stall port; registers load every cycle.

Test Plan:
- Reset: assert reset between clock edges -> result_r = 0x0000 and CCR = 000 immediately; both stay 0 until reset is released.
- ADD with clear carry: Op1 = 15, Op2 = 24, ALUmode = 00, carrySelect = 10, repeated 4 cycles -> result_r = 39 (0x0027), CCR = 000 each cycle after the first edge.
- ADD carry/zero: Op1 = 0xFFFF, Op2 = 0x0001, ALUmode = 00, carrySelect = 00 -> result_r = 0x0000, CCR = 101 (C = 1, Z = 1).
- SUB borrow/negative: Op1 = 5, Op2 = 7, ALUmode = 01, carrySelect = 00 -> result_r = 0xFFFE, CCR = 110 (C = 1, N = 1).
- Logic plus carry control:
  - Op1 = 0x00F0, Op2 = 0x0F0F, ALUmode = 10, carrySelect = 01 -> result_r = 0x0000, CCR = 101.
  - Then ALUmode = 11, carrySelect = 11 -> result_r = 0x0FFF, CCR = 100 (C held).
- Stall (EXEC_STALL_EN): with result_r = 39, apply new operands 1 + 1 with stall = 1 for 2 cycles -> result_r stays 39; release stall -> result_r = 2 after the next edge.
